// File: rtl/egress_fifo_scheduler.sv
// Frame-granular round-robin scheduler draining N ingress FIFO read ports
// onto one egress word handshake; all logic in the rclk domain.
module egress_fifo_scheduler #(
  parameter int N_PORTS         = 4,
  parameter int DATA_W          = 8,
  parameter int MAX_FRAME_WORDS = 1522
) (
  input  logic                            rclk,
  input  logic                            reset,
  input  logic [N_PORTS-1:0]              fifo_empty,
  output logic [N_PORTS-1:0]              fifo_rd_en,
  input  logic [N_PORTS*(DATA_W+1)-1:0]   fifo_rd_data,
  output logic [DATA_W-1:0]               out_data,
  output logic                            out_eof,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(N_PORTS)-1:0]      grant_id,
  output logic                            busy,
  output logic [15:0]                     frame_cnt,
  output logic                            trunc_err
);

  localparam int GW = $clog2(N_PORTS);
  localparam int SW = DATA_W + 1;
  localparam int CW = $clog2(MAX_FRAME_WORDS + 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    SEND
  } state_e;

  state_e              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [GW-1:0]       last_q, last_d;
  logic [CW-1:0]       wcnt_q, wcnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                eof_q, eof_d;
  logic                valid_q, valid_d;
  logic                trunc_q, trunc_d;
  logic [15:0]         fcnt_q, fcnt_d;

  logic [GW-1:0]       rr_pick;
  logic                rr_hit;
  logic [GW-1:0]       cand;
  logic [SW-1:0]       slice;
  logic [CW-1:0]       wcnt_inc;

  // First non-empty port strictly after the last frame's owner.
  always_comb begin
    rr_pick = last_q;
    rr_hit  = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      cand = GW'((int'(last_q) + k) % N_PORTS);
      if (!rr_hit && !fifo_empty[cand]) begin
        rr_pick = cand;
        rr_hit  = 1'b1;
      end
    end
  end

  assign slice    = fifo_rd_data[int'(grant_q)*SW +: SW];
  assign wcnt_inc = wcnt_q + CW'(1);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    wcnt_d     = wcnt_q;
    data_d     = data_q;
    eof_d      = eof_q;
    valid_d    = valid_q;
    fcnt_d     = fcnt_q;
    trunc_d    = 1'b0;
    fifo_rd_en = '0;
    unique case (state_q)
      IDLE: begin
        if (rr_hit) begin
          grant_d = rr_pick;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (!fifo_empty[grant_q]) begin
          fifo_rd_en[grant_q] = 1'b1;
          state_d             = WAIT;
        end
      end
      WAIT: begin
        data_d  = slice[DATA_W-1:0];
        eof_d   = slice[DATA_W];
        valid_d = 1'b1;
        wcnt_d  = wcnt_inc;
        if (wcnt_inc == CW'(MAX_FRAME_WORDS) && !slice[DATA_W]) begin
          eof_d   = 1'b1;
          trunc_d = 1'b1;
        end
        state_d = SEND;
      end
      SEND: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          if (eof_q) begin
            fcnt_d  = fcnt_q + 16'd1;
            last_d  = grant_q;
            wcnt_d  = '0;
            state_d = IDLE;
          end else begin
            state_d = FETCH;
          end
        end
      end
    endcase
  end

  always_ff @(posedge rclk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(N_PORTS - 1);
      wcnt_q  <= '0;
      data_q  <= '0;
      eof_q   <= 1'b0;
      valid_q <= 1'b0;
      trunc_q <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wcnt_q  <= wcnt_d;
      data_q  <= data_d;
      eof_q   <= eof_d;
      valid_q <= valid_d;
      trunc_q <= trunc_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign out_data  = data_q;
  assign out_eof   = eof_q;
  assign out_valid = valid_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q != IDLE);
  assign frame_cnt = fcnt_q;
  assign trunc_err = trunc_q;

endmodule

// File: tb/tb_egress_fifo_scheduler.sv
// Scoreboard bench for egress_fifo_scheduler: FIFO models, frame-level
// round-robin reference, directed scenarios and randomized rounds.
module tb_egress_fifo_scheduler;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int SW   = DW + 1;
  localparam int MAXW = 4;

  logic              rclk;
  logic              reset;
  logic [N-1:0]      fifo_empty;
  logic [N-1:0]      fifo_rd_en;
  logic [N*SW-1:0]   fifo_rd_data;
  logic [DW-1:0]     out_data;
  logic              out_eof;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        grant_id;
  logic              busy;
  logic [15:0]       frame_cnt;
  logic              trunc_err;

  egress_fifo_scheduler #(
    .N_PORTS(N),
    .DATA_W(DW),
    .MAX_FRAME_WORDS(MAXW)
  ) dut (
    .rclk(rclk),
    .reset(reset),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .out_data(out_data),
    .out_eof(out_eof),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .grant_id(grant_id),
    .busy(busy),
    .frame_cnt(frame_cnt),
    .trunc_err(trunc_err)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  typedef struct {
    int         port;
    logic [7:0] d;
    logic       e;
  } exp_t;

  logic [SW-1:0] q[N][$];
  logic [SW-1:0] mq[N][$];
  logic [SW-1:0] rdw[N];
  exp_t          exp_q[$];

  int checks, errors, cyc, trunc_seen;
  int exp_frames, exp_trunc, mlast;
  bit rand_rdy, gap_en;

  always_comb begin
    fifo_rd_data = '0;
    for (int i = 0; i < N; i++) fifo_rd_data[i*SW +: SW] = rdw[i];
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted egress word.
  exp_t me;
  int   prev_cyc;
  bit   have_prev, prev_eof;
  always @(negedge rclk) begin
    cyc++;
    if (reset === 1'b1 && trunc_err === 1'b1) trunc_seen++;
    if (!gap_en) have_prev = 0;
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 32'({grant_id, out_eof, out_data}), 32'hFFFF);
      end else begin
        me = exp_q.pop_front();
        chk("word", 32'({grant_id, out_eof, out_data}),
            32'({2'(me.port), me.e, me.d}));
      end
      if (gap_en && have_prev)
        chk("gap", cyc - prev_cyc, prev_eof ? 32'd4 : 32'd3);
      have_prev = 1;
      prev_cyc  = cyc;
      prev_eof  = out_eof;
    end
  end

  task automatic update_empty();
    for (int i = 0; i < N; i++) fifo_empty[i] = (q[i].size() == 0);
  endtask

  task automatic push_word(int p, logic [SW-1:0] w, bit model);
    q[p].push_back(w);
    if (model) mq[p].push_back(w);
    update_empty();
  endtask

  task automatic push_frame(int p, int len);
    for (int k = 0; k < len; k++)
      push_word(p, {logic'(k == len - 1), 8'($urandom)}, 1'b1);
  endtask

  // Reference: round-robin over ports holding data, one frame per grant,
  // frames cut after MAXW words.
  task automatic predict();
    int p, n, idx;
    bit done;
    logic [SW-1:0] w;
    logic e;
    while (1) begin
      p = -1;
      for (int k = 1; k <= N; k++) begin
        idx = (mlast + k) % N;
        if (p < 0 && mq[idx].size() != 0) p = idx;
      end
      if (p < 0) break;
      n = 0;
      done = 0;
      while (!done && mq[p].size() != 0) begin
        w = mq[p].pop_front();
        n++;
        e = w[DW];
        if (!e && n == MAXW) begin
          e = 1'b1;
          exp_trunc++;
        end
        exp_q.push_back('{p, w[7:0], e});
        done = e;
      end
      exp_frames++;
      mlast = p;
    end
  endtask

  // One rclk cycle of the FIFO models: a strobe seen in a cycle
  // delivers its word just after the following edge.
  task automatic tick();
    logic [N-1:0] rc;
    logic v;
    @(negedge rclk);
    rc = fifo_rd_en;
    v  = out_valid;
    @(posedge rclk);
    #1;
    if (rc != 0) chk("rd_onehot_idle", 32'({$onehot(rc), v}), 32'd2);
    for (int i = 0; i < N; i++) begin
      if (rc[i]) begin
        if (q[i].size() == 0) chk("rd_underflow", 32'(i), 32'hFF);
        else rdw[i] = q[i].pop_front();
      end
    end
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    update_empty();
  endtask

  task automatic drain(int lim);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < lim) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(n < lim), 32'd1);
  endtask

  logic [7:0] a, b, c, d, d0;
  int sz, t0;
  logic [15:0] f0;
  int n;

  initial begin
    reset     = 1'b0;
    out_ready = 1'b1;
    rand_rdy  = 0;
    gap_en    = 0;
    mlast     = N - 1;
    for (int i = 0; i < N; i++) rdw[i] = '0;
    update_empty();

    for (int p = 0; p < N; p++) push_frame(p, 2);
    predict();
    repeat (3) tick();
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_busy_grant", 32'({busy, grant_id}), 32'd0);
    chk("rst_data_trunc", 32'({out_data, out_eof, trunc_err}), 32'd0);

    reset  = 1'b1;
    gap_en = 1;
    tick();
    chk("grant_after_idle", 32'({busy, grant_id}), 32'h4);
    drain(400);
    gap_en = 0;
    chk("rr_frame_cnt", 32'(frame_cnt), 32'd4);

    a = 8'($urandom); b = 8'($urandom);
    c = 8'($urandom); d = 8'($urandom);
    push_word(0, {1'b0, a}, 1'b0);
    push_word(0, {1'b0, b}, 1'b0);
    exp_q.push_back('{0, a, 1'b0});
    exp_q.push_back('{0, b, 1'b0});
    exp_q.push_back('{0, c, 1'b0});
    exp_q.push_back('{0, d, 1'b1});
    repeat (12) tick();
    push_word(3, {1'b0, 8'h3A}, 1'b0);
    push_word(3, {1'b1, 8'h3B}, 1'b0);
    exp_q.push_back('{3, 8'h3A, 1'b0});
    exp_q.push_back('{3, 8'h3B, 1'b1});
    repeat (20) tick();
    chk("stall_p3_untouched", 32'(q[3].size()), 32'd2);
    chk("stall_grant", 32'({busy, grant_id}), 32'h4);
    chk("stall_words_left", 32'(exp_q.size()), 32'd4);
    push_word(0, {1'b0, c}, 1'b0);
    push_word(0, {1'b1, d}, 1'b0);
    exp_frames += 2;
    mlast = 3;
    drain(400);

    push_frame(1, 2);
    push_frame(1, 3);
    push_frame(2, 1);
    predict();
    drain(400);

    out_ready = 1'b0;
    push_frame(0, 2);
    predict();
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    chk("bp_valid_seen", 32'(out_valid), 32'd1);
    d0 = out_data;
    repeat (10) begin
      tick();
      chk("bp_hold", 32'({out_valid, fifo_rd_en, out_data}), 32'({1'b1, 4'b0, d0}));
    end
    sz = exp_q.size();
    out_ready = 1'b1;
    tick();
    chk("bp_accept_first", 32'(exp_q.size()), 32'(sz - 1));
    drain(400);

    t0 = trunc_seen;
    f0 = frame_cnt;
    for (int k = 0; k < 6; k++)
      push_word(2, {logic'(k == 5), 8'($urandom)}, 1'b1);
    predict();
    drain(400);
    chk("trunc_pulse", 32'(trunc_seen - t0), 32'd1);
    chk("trunc_frames", 32'(frame_cnt - f0), 32'd2);

    rand_rdy = 1;
    repeat (25) begin
      for (int p = 0; p < N; p++)
        if ($urandom_range(0, 1) == 1)
          repeat ($urandom_range(1, 3)) push_frame(p, $urandom_range(1, 6));
      predict();
      drain(3000);
    end
    rand_rdy  = 0;
    out_ready = 1'b1;
    tick();

    chk("final_frame_cnt", 32'(frame_cnt), 32'(exp_frames[15:0]));
    chk("final_trunc_cnt", trunc_seen, exp_trunc);
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
